// File: rtl/aclk_keyfsm.sv
`default_nettype none
// ============================================================================
// Module      : aclk_keyfsm
// Description : Alarm-clock keypad front-end. Filters the raw key code,
//               emits one shift per accepted digit, times out abandoned
//               entries and decodes the ALARM/TIME buttons. Define
//               ACLK_KEYFSM_DEBOUNCE_EN for the multi-sample debounce filter.
// Revision    : 1.0 - initial release
// ============================================================================
module aclk_keyfsm #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_SEC     = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic [3:0] key_out,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_new_time,
    output logic       show_alarm
);

    localparam logic [3:0] C_NOKEY   = 4'hA;
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_SEC);
`ifdef ACLK_KEYFSM_DEBOUNCE_EN
    localparam logic [7:0] C_DEPTH   = 8'(DEBOUNCE_CYCLES);
`else
    // A depth of one reduces the filter to a single register stage.
    localparam logic [7:0] C_DEPTH   = 8'd1;
`endif

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] w_key_norm;
    logic [3:0] r_key_last;
    logic [7:0] r_stable_cnt;
    logic [7:0] w_stable_next;
    logic [3:0] r_key_db;
    logic [3:0] r_key_db_prev;
    logic [7:0] r_tcnt;
    logic       w_press;
    logic       w_timeout;
    logic [3:0] r_key_out;
    logic       r_shift;
    logic       r_load_new_a;
    logic       r_load_new_c;
    logic       r_show_new_time;
    logic       r_show_alarm;

    // Codes B..F collapse onto NOKEY so the filter sees only digits or NOKEY.
    assign w_key_norm = (key <= 4'd9) ? key : C_NOKEY;

    always_comb begin
        w_stable_next = 8'd1;
        if (w_key_norm == r_key_last) begin
            w_stable_next = (r_stable_cnt >= C_DEPTH) ? C_DEPTH : r_stable_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_key_last    <= C_NOKEY;
            r_stable_cnt  <= 8'd0;
            r_key_db      <= C_NOKEY;
            r_key_db_prev <= C_NOKEY;
        end else begin
            r_key_last    <= w_key_norm;
            r_stable_cnt  <= w_stable_next;
            if (w_stable_next == C_DEPTH) begin
                r_key_db <= w_key_norm;
            end
            r_key_db_prev <= r_key_db;
        end
    end

    assign w_press   = (r_key_db <= 4'd9) && (r_key_db_prev == C_NOKEY);
    assign w_timeout = (r_tcnt == C_TIMEOUT);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SHOW_TIME: begin
                if (alarm_button)  w_state_next = SHOW_ALARM;
                else if (w_press)  w_state_next = KEY_STORED;
            end
            KEY_STORED:            w_state_next = KEY_WAITED;
            KEY_WAITED: begin
                if (r_key_db == C_NOKEY) w_state_next = KEY_ENTRY;
                else if (w_timeout)      w_state_next = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (alarm_button)      w_state_next = SET_ALARM_TIME;
                else if (time_button)  w_state_next = SET_CURRENT_TIME;
                else if (w_press)      w_state_next = KEY_STORED;
                else if (w_timeout)    w_state_next = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!alarm_button) w_state_next = SHOW_TIME;
            end
            SET_ALARM_TIME:        w_state_next = SHOW_TIME;
            SET_CURRENT_TIME:      w_state_next = SHOW_TIME;
            default:               w_state_next = SHOW_TIME;
        endcase
    end

    // Inactivity counter saturates rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tcnt <= 8'd0;
        end else if (r_state == KEY_WAITED || r_state == KEY_ENTRY) begin
            if (one_second && r_tcnt != 8'hFF) begin
                r_tcnt <= r_tcnt + 8'd1;
            end
        end else begin
            r_tcnt <= 8'd0;
        end
    end

    // Outputs are decoded from the next state so they align with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= SHOW_TIME;
            r_key_out       <= 4'd0;
            r_shift         <= 1'b0;
            r_load_new_a    <= 1'b0;
            r_load_new_c    <= 1'b0;
            r_show_new_time <= 1'b0;
            r_show_alarm    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == KEY_STORED) begin
                r_key_out <= r_key_db;
            end
            r_shift         <= (w_state_next == KEY_STORED);
            r_load_new_a    <= (w_state_next == SET_ALARM_TIME);
            r_load_new_c    <= (w_state_next == SET_CURRENT_TIME);
            r_show_new_time <= (w_state_next == KEY_STORED) ||
                               (w_state_next == KEY_WAITED) ||
                               (w_state_next == KEY_ENTRY);
            r_show_alarm    <= (w_state_next == SHOW_ALARM);
        end
    end

    assign key_out       = r_key_out;
    assign shift         = r_shift;
    assign load_new_a    = r_load_new_a;
    assign load_new_c    = r_load_new_c;
    assign show_new_time = r_show_new_time;
    assign show_alarm    = r_show_alarm;

endmodule
`default_nettype wire

// File: tb/tb_aclk_keyfsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_aclk_keyfsm
// Description : Directed self-checking bench for aclk_keyfsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aclk_keyfsm;

    localparam int DEB = 4;
    localparam int TMO = 10;
`ifdef ACLK_KEYFSM_DEBOUNCE_EN
    localparam int LAT = DEB;
`else
    localparam int LAT = 1;
`endif

    logic       clock        = 1'b0;
    logic       reset        = 1'b1;
    logic       one_second   = 1'b0;
    logic [3:0] key          = 4'hA;
    logic       alarm_button = 1'b0;
    logic       time_button  = 1'b0;
    logic [3:0] key_out;
    logic       shift;
    logic       load_new_a;
    logic       load_new_c;
    logic       show_new_time;
    logic       show_alarm;

    int n_checks = 0;
    int n_pass   = 0;
    int n_shift  = 0;
    int n_la     = 0;
    int n_lc     = 0;
    int n_wide   = 0;
    int n_coinc  = 0;
    int bad      = 0;
    logic [3:0] key_log [0:7];
    logic p_shift = 1'b0;
    logic p_la    = 1'b0;
    logic p_lc    = 1'b0;

    aclk_keyfsm #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_SEC     (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .key           (key),
        .alarm_button  (alarm_button),
        .time_button   (time_button),
        .key_out       (key_out),
        .shift         (shift),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c),
        .show_new_time (show_new_time),
        .show_alarm    (show_alarm)
    );

    always #5 clock = ~clock;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (shift === 1'b1) begin
                if (n_shift < 8) key_log[n_shift] = key_out;
                n_shift++;
            end
            if (load_new_a === 1'b1) n_la++;
            if (load_new_c === 1'b1) n_lc++;
            if ((shift && p_shift) || (load_new_a && p_la) || (load_new_c && p_lc)) n_wide++;
            if (int'(shift) + int'(load_new_a) + int'(load_new_c) > 1) n_coinc++;
            p_shift = shift;
            p_la    = load_new_a;
            p_lc    = load_new_c;
        end
    endtask

    task automatic clear_counts();
        n_shift = 0;
        n_la    = 0;
        n_lc    = 0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        key          = 4'hA;
        alarm_button = 1'b0;
        time_button  = 1'b0;
        one_second   = 1'b0;
        run(2);
        reset = 1'b0;
        clear_counts();
    endtask

    task automatic press_digit(input logic [3:0] d);
        key = d;
        run(LAT);
        key = 4'hA;
        run(LAT + 3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run(1);
        n_checks++; if ({shift, load_new_a, load_new_c, show_new_time, show_alarm, key_out} !== 9'b0)
            $display("FAIL reset_outputs: got %b want %b", {shift, load_new_a, load_new_c, show_new_time, show_alarm, key_out}, 9'b0);
            else n_pass++;
        reset = 1'b0;
        clear_counts();
        key = 4'h5;
        run(LAT + 1);
        n_checks++; if (shift !== 1'b1) $display("FAIL pre_reset_shift: got %b want 1", shift); else n_pass++;
        run(1);
        n_checks++; if ({shift, show_new_time} !== 2'b01)
            $display("FAIL pre_reset_waited: got %b want 01", {shift, show_new_time}); else n_pass++;
        reset = 1'b1;
        key   = 4'hA;
        run(1);
        n_checks++; if ({shift, load_new_a, load_new_c, show_new_time, show_alarm, key_out} !== 9'b0)
            $display("FAIL midreset_outputs: got %b want %b", {shift, load_new_a, load_new_c, show_new_time, show_alarm, key_out}, 9'b0);
            else n_pass++;
        reset = 1'b0;
        run(1);
        n_checks++; if ({shift, load_new_a, load_new_c, show_new_time, show_alarm} !== 5'b0)
            $display("FAIL postreset_outputs: got %b want 00000", {shift, load_new_a, load_new_c, show_new_time, show_alarm});
            else n_pass++;
        n_checks++; if (n_shift + n_la + n_lc !== 1)
            $display("FAIL midreset_pulses: got %0d want 1", n_shift + n_la + n_lc); else n_pass++;
    endtask

    task automatic test_single_press();
        do_reset();
        key = 4'h7;
        bad = 0;
        for (int i = 0; i < LAT; i++) begin
            run(1);
            if (shift !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL press_early_shift: got %0d want 0", bad); else n_pass++;
        key = 4'hA;
        run(1);
        n_checks++; if ({shift, show_new_time, key_out} !== 6'b11_0111)
            $display("FAIL press_shift: got %b want 110111", {shift, show_new_time, key_out}); else n_pass++;
        run(1);
        n_checks++; if (shift !== 1'b0) $display("FAIL press_width: got %b want 0", shift); else n_pass++;
        run(LAT + 2);
        key = 4'hC;
        run(3);
        key = 4'hA;
        run(LAT + 3);
`ifdef ACLK_KEYFSM_DEBOUNCE_EN
        key = 4'h3;
        run(3);
        key = 4'hA;
        run(LAT + 3);
`endif
        n_checks++; if (n_shift !== 1) $display("FAIL press_count: got %0d want 1", n_shift); else n_pass++;
        n_checks++; if ({show_new_time, key_out} !== 5'b1_0111)
            $display("FAIL press_entry_hold: got %b want 10111", {show_new_time, key_out}); else n_pass++;
    endtask

    task automatic test_alarm_entry();
        do_reset();
        for (int d = 1; d <= 4; d++) press_digit(4'(d));
        n_checks++; if (n_shift !== 4) $display("FAIL entry_shift_count: got %0d want 4", n_shift); else n_pass++;
        n_checks++; if ({key_log[0], key_log[1], key_log[2], key_log[3]} !== 16'h1234)
            $display("FAIL entry_digits: got %h want 1234", {key_log[0], key_log[1], key_log[2], key_log[3]}); else n_pass++;
        alarm_button = 1'b1;
        run(1);
        n_checks++; if ({load_new_a, load_new_c, shift, show_new_time} !== 4'b1000)
            $display("FAIL entry_load_a: got %b want 1000", {load_new_a, load_new_c, shift, show_new_time}); else n_pass++;
        alarm_button = 1'b0;
        run(1);
        n_checks++; if ({load_new_a, load_new_c, shift, show_new_time, show_alarm} !== 5'b0)
            $display("FAIL entry_after_load: got %b want 00000", {load_new_a, load_new_c, shift, show_new_time, show_alarm}); else n_pass++;
        run(3);
        n_checks++; if ({n_la, n_lc} !== {32'd1, 32'd0})
            $display("FAIL entry_load_counts: got a=%0d c=%0d want a=1 c=0", n_la, n_lc); else n_pass++;
    endtask

    task automatic test_time_load();
        do_reset();
        press_digit(4'h8);
        time_button = 1'b1;
        run(1);
        n_checks++; if ({load_new_a, load_new_c, shift, show_new_time} !== 4'b0100)
            $display("FAIL time_load_c: got %b want 0100", {load_new_a, load_new_c, shift, show_new_time}); else n_pass++;
        time_button = 1'b0;
        run(2);
        n_checks++; if ({n_la, n_lc, 31'd0, show_new_time} !== {32'd0, 32'd1, 32'd0})
            $display("FAIL time_load_after: got a=%0d c=%0d snt=%b want a=0 c=1 snt=0", n_la, n_lc, show_new_time); else n_pass++;
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) begin
            one_second = 1'b1;
            run(1);
            one_second = 1'b0;
            if (t != n - 1) run(2);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        press_digit(4'h5);
        ticks(TMO - 1);
        run(5);
        n_checks++; if (show_new_time !== 1'b1) $display("FAIL timeout_9_ticks: got %b want 1", show_new_time); else n_pass++;
        ticks(1);
        n_checks++; if (show_new_time !== 1'b1) $display("FAIL timeout_tick10_edge: got %b want 1", show_new_time); else n_pass++;
        run(1);
        n_checks++; if (show_new_time !== 1'b0) $display("FAIL timeout_exit: got %b want 0", show_new_time); else n_pass++;
        n_checks++; if ({n_shift, n_la, n_lc} !== {32'd1, 32'd0, 32'd0})
            $display("FAIL timeout_pulses: got s=%0d a=%0d c=%0d want s=1 a=0 c=0", n_shift, n_la, n_lc); else n_pass++;
        // stuck key: stays in KEY_WAITED until the timeout fires
        do_reset();
        key = 4'h6;
        run(LAT + 2);
        ticks(TMO);
        n_checks++; if (show_new_time !== 1'b1) $display("FAIL stuck_tick10_edge: got %b want 1", show_new_time); else n_pass++;
        run(1);
        n_checks++; if ({show_new_time, 31'd0, n_shift} !== {32'd0, 32'd1})
            $display("FAIL stuck_exit: got snt=%b s=%0d want snt=0 s=1", show_new_time, n_shift); else n_pass++;
        key = 4'hA;
        run(LAT + 3);
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_digit(4'h2);
        clear_counts();
        key = 4'h9;
        run(LAT);
        n_checks++; if ({shift, show_new_time} !== 2'b01)
            $display("FAIL simul_pre: got %b want 01", {shift, show_new_time}); else n_pass++;
        alarm_button = 1'b1;
        time_button  = 1'b1;
        run(1);
        n_checks++; if ({load_new_a, load_new_c, shift} !== 3'b100)
            $display("FAIL simul_edge: got %b want 100", {load_new_a, load_new_c, shift}); else n_pass++;
        alarm_button = 1'b0;
        time_button  = 1'b0;
        key          = 4'hA;
        run(2 * LAT + 4);
        n_checks++; if ({n_shift, n_la, n_lc} !== {32'd0, 32'd1, 32'd0})
            $display("FAIL simul_pulses: got s=%0d a=%0d c=%0d want s=0 a=1 c=0", n_shift, n_la, n_lc); else n_pass++;
        n_checks++; if (show_new_time !== 1'b0) $display("FAIL simul_state: got %b want 0", show_new_time); else n_pass++;
    endtask

    task automatic test_show_alarm();
        do_reset();
        alarm_button = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            run(1);
            if (show_alarm !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL show_alarm_held: got %0d low cycles want 0", bad); else n_pass++;
        alarm_button = 1'b0;
        run(1);
        n_checks++; if (show_alarm !== 1'b0) $display("FAIL show_alarm_release: got %b want 0", show_alarm); else n_pass++;
        time_button = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            run(1);
            if ({shift, load_new_a, load_new_c, show_new_time, show_alarm} !== 5'b0) bad++;
        end
        time_button = 1'b0;
        n_checks++; if (bad !== 0) $display("FAIL time_alone: got %0d active cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_pulse_rules();
        n_checks++; if (n_wide !== 0) $display("FAIL pulse_width: got %0d wide pulses want 0", n_wide); else n_pass++;
        n_checks++; if (n_coinc !== 0) $display("FAIL pulse_overlap: got %0d overlaps want 0", n_coinc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_alarm_entry();
        test_time_load();
        test_timeout();
        test_simultaneous();
        test_show_alarm();
        test_pulse_rules();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
